// File: rtl/sg_window_buffer_pkg.sv
// sg_pkg: shared window geometry, sample/window types and buffer states for the Savitzky-Golay path
package sg_pkg;
  localparam int WINDOW_SIZE = 7;
  localparam int HALF = WINDOW_SIZE / 2;
  localparam int DATA_W = 32;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [WINDOW_SIZE-1:0] window_t;
  typedef enum logic [1:0] {WB_FILL, WB_RUN, WB_FLUSH} wb_state_e;
endpackage

// File: rtl/sg_window_buffer_if.sv
// sg_window_buffer_if: sample stream in, window stream out; master drives samples, slave is the buffer
interface sg_window_buffer_if #(parameter int IDX_W = 10);
  import sg_pkg::*;
  logic s_valid, s_ready, s_last;
  sample_t s_data;
  logic m_valid, m_ready, m_last, done;
  window_t m_window;
  logic [IDX_W-1:0] m_center;
  modport master (output s_valid, s_data, s_last, m_ready,
                  input s_ready, m_valid, m_window, m_center, m_last, done);
  modport slave (input s_valid, s_data, s_last, m_ready,
                 output s_ready, m_valid, m_window, m_center, m_last, done);
endinterface

// File: rtl/sg_window_buffer_shift_reg.sv
// sg_shift_reg: W-deep window register; shift puts din at slot W-1, fill replicates din into every slot
module sg_shift_reg import sg_pkg::*; (
  input  logic    clk,
  input  logic    rst,
  input  logic    shift,
  input  logic    fill,
  input  sample_t din,
  output window_t q
);
  window_t win_d, win_q;
  always_comb begin
    win_d = win_q;
    if (fill) win_d = {WINDOW_SIZE{din}};
    else if (shift) win_d = {din, win_q[WINDOW_SIZE-1:1]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) win_q <= '0;
    else win_q <= win_d;
  assign q = win_q;
endmodule

// File: rtl/sg_window_buffer.sv
// sg_window_buffer: turns a sample record into a stream of sliding windows with centre index.
// Define SG_EDGE_PAD_EN to replicate edge samples so every input sample gets its own window.
module sg_window_buffer import sg_pkg::*; #(
  parameter int DATA_SIZE = 1000,
  parameter int IDX_W = $clog2(DATA_SIZE)
) (
  input logic clk,
  input logic rst,
  sg_window_buffer_if.slave bus
);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_MAX = IDX_W'(DATA_SIZE - 1);
`ifdef SG_EDGE_PAD_EN
  localparam logic [IDX_W-1:0] FIRST = IDX_W'(HALF + 1);
  localparam logic [IDX_W-1:0] C0 = '0;
`else
  localparam logic [IDX_W-1:0] FIRST = IDX_W'(WINDOW_SIZE);
  localparam logic [IDX_W-1:0] C0 = IDX_W'(HALF);
`endif
  wb_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, center_q, center_d, cnt_nx;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, done_q, done_d, live_q;
  logic adv_ok, accept, push, adv, emit, last_win, fill;
  sample_t din;
  window_t win;
  assign adv_ok = !m_valid_q || bus.m_ready;
  assign accept = m_valid_q && bus.m_ready;
  // a pending final window blocks the next record until it is taken
  assign bus.s_ready = live_q && state_q != WB_FLUSH && !m_last_q && adv_ok;
  assign push = bus.s_valid && bus.s_ready;
  assign cnt_nx = cnt_q == FIRST ? FIRST : cnt_q + ONE;
  assign emit = adv && cnt_nx == FIRST;
`ifdef SG_EDGE_PAD_EN
  logic [IDX_W-1:0] fl_q, fl_d;
  logic flush_adv;
  assign flush_adv = state_q == WB_FLUSH && fl_q != '0 && adv_ok;
  assign adv = push || flush_adv;
  assign last_win = flush_adv && fl_q == ONE;
  assign fill = push && cnt_q == '0;
  assign din = push ? bus.s_data : win[WINDOW_SIZE-1];
`else
  assign adv = push;
  assign last_win = push && bus.s_last;
  assign fill = 1'b0;
  assign din = bus.s_data;
`endif
  sg_shift_reg u_shift (.clk(clk), .rst(rst), .shift(adv), .fill(fill), .din(din), .q(win));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    center_d = center_q;
    m_valid_d = m_valid_q && !bus.m_ready;
    m_last_d = m_last_q;
    done_d = 1'b0;
`ifdef SG_EDGE_PAD_EN
    fl_d = fl_q;
`endif
    if (accept && m_last_q) begin
      state_d = WB_FILL;
      cnt_d = '0;
      center_d = '0;
      m_last_d = 1'b0;
      done_d = 1'b1;
    end
    if (adv) begin
      cnt_d = cnt_nx;
      if (emit) begin
        m_valid_d = 1'b1;
        m_last_d = last_win;
        center_d = cnt_q == FIRST ? (center_q == C_MAX ? C_MAX : center_q + ONE) : C0;
        state_d = WB_RUN;
      end
`ifdef SG_EDGE_PAD_EN
      if (flush_adv) begin
        fl_d = fl_q - ONE;
        state_d = WB_FLUSH;
      end
      if (push && bus.s_last) begin
        fl_d = IDX_W'(HALF);
        state_d = WB_FLUSH;
      end
`else
      if (push && bus.s_last && !emit) begin
        state_d = WB_FILL;
        cnt_d = '0;
        done_d = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= WB_FILL;
      cnt_q <= '0;
      center_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      done_q <= 1'b0;
      live_q <= 1'b0;
`ifdef SG_EDGE_PAD_EN
      fl_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      center_q <= center_d;
      m_valid_q <= m_valid_d;
      m_last_q <= m_last_d;
      done_q <= done_d;
      live_q <= 1'b1;
`ifdef SG_EDGE_PAD_EN
      fl_q <= fl_d;
`endif
    end
  assign bus.m_valid = m_valid_q;
  assign bus.m_window = win;
  assign bus.m_center = center_q;
  assign bus.m_last = m_last_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_sg_window_buffer.sv
// tb_sg_window_buffer: directed records into sg_window_buffer, windows checked by a scoreboard monitor
module tb_sg_window_buffer;
  import sg_pkg::*;
  typedef struct { window_t w; int c; bit l; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sg_window_buffer_if #(.IDX_W(10)) bus();
  sg_window_buffer #(.DATA_SIZE(1000)) dut (.clk(clk), .rst(rst), .bus(bus));
  exp_t sb[$];
  int checks = 0, errors = 0, done_cnt = 0, exp_done = 0, acc_cnt = 0, stall_left = 0;
  bit mon_en = 1'b1, rnd_r = 1'b0, done_pend = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int w[0:WINDOW_SIZE-1], input int c, input bit l);
    exp_t e;
    for (int j = 0; j < WINDOW_SIZE; j++) e.w[j] = sample_t'(w[j]);
    e.c = c;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic expect_rec(input int xs[$]);
    int n, lo, hi;
    int w[0:WINDOW_SIZE-1];
    n = xs.size();
`ifdef SG_EDGE_PAD_EN
    lo = 0;
    hi = n - 1;
`else
    lo = HALF;
    hi = n - 1 - HALF;
`endif
    for (int c = lo; c <= hi; c++) begin
      for (int j = 0; j < WINDOW_SIZE; j++) begin
        int k;
        k = c - HALF + j;
        k = k < 0 ? 0 : (k > n - 1 ? n - 1 : k);
        w[j] = xs[k];
      end
      push_exp(w, c, c == hi);
    end
    exp_done++;
  endtask

  task automatic send(input int xs[$], input bit rnd_v, input bit last_en);
    int i = 0, g = 0;
    while (i < xs.size() && g < 20000) begin
      @(posedge clk); #1;
      bus.s_valid = rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_data = xs[i];
      bus.s_last = last_en && (i == xs.size() - 1);
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) i++;
      g++;
    end
    chk("send_complete", 256'(i), 256'(xs.size()));
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", 256'(sb.size()), 256'(0));
    repeat (4) @(negedge clk);
    chk("done_count", 256'(done_cnt), 256'(exp_done));
  endtask

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        bus.m_ready = 1'b0;
        stall_left--;
      end else bus.m_ready = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_pend) begin
      chk("done_after_last", 256'(bus.done), 256'(1));
      done_pend = 1'b0;
    end
    if (bus.done) done_cnt++;
    if (mon_en && rst && bus.m_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: center %0d with empty scoreboard", bus.m_center);
      end else if (bus.m_ready) begin
        chk("window", 256'(bus.m_window), 256'(sb[0].w));
        chk("center", 256'(bus.m_center), 256'(sb[0].c));
        chk("last", 256'(bus.m_last), 256'(sb[0].l));
        if (sb[0].l) done_pend = 1'b1;
        sb.delete(0);
        acc_cnt++;
      end else begin
        chk("stall_window", 256'(bus.m_window), 256'(sb[0].w));
        chk("stall_center", 256'(bus.m_center), 256'(sb[0].c));
        chk("stall_s_ready", 256'(bus.s_ready), 256'(0));
      end
    end
  end

  initial begin
    int xs[$];
    int w[0:WINDOW_SIZE-1];
    int d0, a0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    #12;
    chk("rst_m_valid", 256'(bus.m_valid), 256'(0));
    chk("rst_s_ready", 256'(bus.s_ready), 256'(0));
    chk("rst_m_last", 256'(bus.m_last), 256'(0));
    chk("rst_done", 256'(bus.done), 256'(0));
    chk("rst_window", 256'(bus.m_window), 256'(0));
    chk("rst_center", 256'(bus.m_center), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    #1 chk("s_ready_before_clk", 256'(bus.s_ready), 256'(0));
    @(posedge clk); #1;
    chk("s_ready_after_clk", 256'(bus.s_ready), 256'(1));

    xs = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
`ifdef SG_EDGE_PAD_EN
    expect_rec(xs);
`else
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < WINDOW_SIZE; j++) w[j] = k + j;
      push_exp(w, 3 + k, k == 3);
    end
    exp_done++;
`endif
    send(xs, 1'b0, 1'b1);
    drain();

    xs.delete();
    for (int i = 0; i < 20; i++) xs.push_back(200 + i);
    expect_rec(xs);
    fork
      send(xs, 1'b0, 1'b1);
      begin
        for (int t = 0; t < 1000 && acc_cnt < 3; t++) @(negedge clk);
        stall_left = 5;
      end
    join
    drain();

`ifdef SG_EDGE_PAD_EN
    begin
      int t3 [0:3][0:6] = '{'{10, 10, 10, 10, 20, 30, 40}, '{10, 10, 10, 20, 30, 40, 40},
                            '{10, 10, 20, 30, 40, 40, 40}, '{10, 20, 30, 40, 40, 40, 40}};
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < WINDOW_SIZE; j++) w[j] = t3[k][j];
        push_exp(w, k, k == 3);
      end
      exp_done++;
      xs = {10, 20, 30, 40};
      send(xs, 1'b0, 1'b1);
      drain();
    end
`endif

    mon_en = 1'b0;
    d0 = done_cnt;
    xs = {50, 51, 52, 53, 54};
    send(xs, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_m_valid", 256'(bus.m_valid), 256'(0));
    chk("abort_s_ready", 256'(bus.s_ready), 256'(0));
    chk("abort_m_last", 256'(bus.m_last), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    chk("abort_no_done", 256'(done_cnt), 256'(d0));
    xs = {100, 101, 102, 103, 104, 105, 106};
`ifdef SG_EDGE_PAD_EN
    expect_rec(xs);
`else
    w = '{100, 101, 102, 103, 104, 105, 106};
    push_exp(w, 3, 1'b1);
    exp_done++;
`endif
    send(xs, 1'b0, 1'b1);
    drain();

    xs = {7, 8, 9};
    expect_rec(xs);
    send(xs, 1'b0, 1'b1);
    drain();

    xs.delete();
    for (int i = 0; i < 1000; i++) xs.push_back(int'($urandom));
    expect_rec(xs);
    a0 = acc_cnt;
    rnd_r = 1'b1;
    send(xs, 1'b1, 1'b1);
    drain();
    rnd_r = 1'b0;
`ifdef SG_EDGE_PAD_EN
    chk("rec1000_windows", 256'(acc_cnt - a0), 256'(1000));
`else
    chk("rec1000_windows", 256'(acc_cnt - a0), 256'(994));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
